// File: rtl/shift_add_mult_if.sv
// rtl/shift_add_mult_if.sv - start/busy/done request bus for the shift-add multiplier
// signed_op exists only when SIGNED_MODE_EN is defined.
interface shift_add_mult_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     multiplier;
  logic [WIDTH-1:0]     multiplicand;
`ifdef SIGNED_MODE_EN
  logic                 signed_op;
`endif
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

`ifdef SIGNED_MODE_EN
  modport master (
    output start, multiplier, multiplicand, signed_op,
    input  busy, done, product
  );
  modport slave (
    input  start, multiplier, multiplicand, signed_op,
    output busy, done, product
  );
`else
  modport master (
    output start, multiplier, multiplicand,
    input  busy, done, product
  );
  modport slave (
    input  start, multiplier, multiplicand,
    output busy, done, product
  );
`endif
endinterface

// File: rtl/shift_add_mult.sv
// rtl/shift_add_mult.sv - sequential shift-and-add WIDTH x WIDTH multiplier, one bit per clock
// Optional two's-complement mode under macro SIGNED_MODE_EN (adds signed_op on the bus).
module shift_add_mult #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  shift_add_mult_if.slave   bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 sign_q, sign_d;
  logic                 sign_in;

  logic [WIDTH:0]       a_ext;
  logic [WIDTH:0]       b_ext;
  logic [WIDTH:0]       sum;
  logic                 last_step;

`ifdef SIGNED_MODE_EN
  assign sign_in = bus.signed_op;
`else
  assign sign_in = 1'b0;
`endif

  // In signed mode the multiplier's MSB carries weight -2^(WIDTH-1), so the last partial product is subtracted.
  always_comb begin
    a_ext     = {sign_q & a_q[WIDTH-1], a_q};
    b_ext     = {sign_q & b_q[WIDTH-1], b_q};
    last_step = (count_q == CW'(1));
    if (!q_q[0]) begin
      sum = a_ext;
    end else if (sign_q && last_step) begin
      sum = a_ext - b_ext;
    end else begin
      sum = a_ext + b_ext;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    q_d       = q_q;
    count_d   = count_q;
    product_d = product_q;
    sign_d    = sign_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_CALC;
          a_d     = '0;
          b_d     = bus.multiplicand;
          q_d     = bus.multiplier;
          count_d = CW'(WIDTH);
          sign_d  = sign_in;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        a_d     = sum[WIDTH:1];
        q_d     = {sum[0], q_q[WIDTH-1:1]};
        count_d = count_q - CW'(1);
        if (last_step) begin
          product_d = {sum, q_q[WIDTH-1:1]};
          state_d   = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      q_q       <= '0;
      count_q   <= '0;
      product_q <= '0;
      sign_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      q_q       <= q_d;
      count_q   <= count_d;
      product_q <= product_d;
      sign_q    <= sign_d;
    end
  end

  assign bus.busy    = (state_q == S_CALC);
  assign bus.done    = (state_q == S_DONE);
  assign bus.product = product_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// tb/tb_shift_add_mult.sv - randomized scoreboard bench for shift_add_mult
// Signed cases are exercised when SIGNED_MODE_EN is defined.
module tb_shift_add_mult;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shift_add_mult_if #(.WIDTH(W)) bus ();

  shift_add_mult #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [2*W-1:0] p;
    int             c;
  } exp_t;

  exp_t sb[$];

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    longint x, y;
    logic [63:0] p;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    p = 64'(x * y);
    return p[2*W-1:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    bus.start        = 1'b1;
    bus.multiplier   = a;
    bus.multiplicand = b;
`ifdef SIGNED_MODE_EN
    bus.signed_op    = s;
`else
    if (s) $display("note: signed request issued without signed mode");
`endif
  endtask

  // Called at a negedge; returns at the negedge where the next request may be driven.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input bit hold, input int gap);
    drive(a, b, s);
    @(posedge clk);
    #1;
    sb.push_back('{model(b, a, s), cyc});
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
    repeat (W + gap) @(negedge clk);
  endtask

  // Monitor: compares each done against the scoreboard and watches busy/product behaviour.
  logic [2*W-1:0] prev_product = '0;
  int             busy_run = 0;
  exp_t           e;

  always @(negedge clk) begin
    if (!reset) begin
      prev_product = '0;
      busy_run     = 0;
    end else begin
      if (bus.done) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pending result", cyc);
        end else begin
          e = sb.pop_front();
          chk("product", 64'(bus.product), 64'(e.p));
          chk("done_latency", 64'(cyc - e.c), 64'(W));
        end
        chk("busy_with_done", 64'(bus.busy), 64'd0);
      end
      if (bus.product !== prev_product) begin
        chk("product_change_on_done", 64'(bus.done), 64'd1);
        prev_product = bus.product;
      end
      if (bus.busy) begin
        busy_run++;
      end else if (busy_run != 0) begin
        chk("busy_cycles", 64'(busy_run), 64'(W));
        busy_run = 0;
      end
    end
  end

  logic [W-1:0] ra, rb;
  logic         rs;

  initial begin
    reset            = 1'b0;
    bus.start        = 1'b0;
    bus.multiplier   = '0;
    bus.multiplicand = '0;
`ifdef SIGNED_MODE_EN
    bus.signed_op    = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_product", 64'(bus.product), 64'd0);
    #1 reset = 1'b1;
    @(negedge clk);

    do_op(8'hFF, 8'hFF, 1'b0, 1'b0, 1);
    do_op(8'h00, 8'hA5, 1'b0, 1'b0, 1);

    // A second start three cycles into an operation must be ignored.
    drive(8'h12, 8'h34, 1'b0);
    @(posedge clk);
    #1;
    sb.push_back('{16'h03A8, cyc});
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    drive(8'h56, 8'h78, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (W - 2) @(negedge clk);

    do_op(8'h0F, 8'h0F, 1'b0, 1'b1, 0);
    do_op(8'h80, 8'h02, 1'b0, 1'b0, 1);

    // Reset four cycles into an operation aborts it without a done pulse.
    drive(8'hAA, 8'h55, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_product", 64'(bus.product), 64'd0);
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    do_op(8'h02, 8'h03, 1'b0, 1'b0, 1);

`ifdef SIGNED_MODE_EN
    do_op(8'h80, 8'h80, 1'b1, 1'b0, 1);
    do_op(8'hFF, 8'h01, 1'b1, 1'b0, 1);
    do_op(8'h7F, 8'h81, 1'b1, 1'b0, 1);
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, 1);
`endif

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
`ifdef SIGNED_MODE_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      do_op(ra, rb, rs, 1'b0, int'($urandom_range(0, 2)));
    end

    repeat (W + 4) @(negedge clk);
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d results still pending, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
